// File: rtl/decoder_seq_pkg.sv
// Shared types and constants for the ji3 decoder/sequencer: op codes, branch codes,
// phase indices, opcode bytes and the decoded control-field struct.
package ji3_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_CMP = 4'd2,  OP_AND = 4'd3,
    OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_NEG = 4'd6,  OP_NOT = 4'd7,
    OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_LD  = 4'd11,
    OP_ST  = 4'd12, OP_MOV = 4'd13, OP_LIL = 4'd14, OP_HLT = 4'd15
  } op_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_B    = 2'b10;
  localparam logic [1:0] BR_BCC  = 2'b01;

  localparam int PH_F = 0;
  localparam int PH_R = 1;
  localparam int PH_X = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  typedef enum logic [2:0] {S_F, S_R, S_X, S_M, S_W} state_t;

  localparam logic [7:0] OPC_LD    = 8'h8B;
  localparam logic [7:0] OPC_MOVST = 8'h89;
  localparam logic [7:0] OPC_LIL   = 8'h66;
  localparam logic [7:0] OPC_ADD   = 8'h01;
  localparam logic [7:0] OPC_SUB   = 8'h29;
  localparam logic [7:0] OPC_CMP   = 8'h39;
  localparam logic [7:0] OPC_AND   = 8'h21;
  localparam logic [7:0] OPC_OR    = 8'h09;
  localparam logic [7:0] OPC_XOR   = 8'h31;
  localparam logic [7:0] OPC_ALUI  = 8'h83;
  localparam logic [7:0] OPC_UNARY = 8'hF7;
  localparam logic [7:0] OPC_SHI   = 8'hC1;
  localparam logic [7:0] OPC_JMP   = 8'h90;
  localparam logic [7:0] OPC_HLT   = 8'hF4;

  typedef struct packed {
    op_t        op;
    logic       use_im;
    logic [1:0] br;
    logic       load;    // LD: load_en level for the whole instruction
    logic       st;      // memory write in X
    logic       wr_reg;  // register-file write in M
    logic       jmp;     // branch commit in M
    logic       hlt;
  } ctl_t;

endpackage

// File: rtl/decoder_seq_if.sv
// Instruction handshake plus decoded-control bus between fetch, decoder and ALU/regfile.
// ir is transferred on a rising edge where ir_valid & ir_ready; ir_valid may rise freely,
// ir_ready never depends on ir_valid, and ir must be stable while ir_valid is high.
interface decoder_seq_if #(
  parameter int DW  = 32,
  parameter int RAW = 3
) ();
  logic           ir_valid;
  logic           ir_ready;
  logic [31:0]    ir;
  logic           stall;
  logic [4:0]     phase;
  logic [3:0]     op;
  logic [DW-1:0]  im;
  logic           use_im;
  logic [1:0]     br;
  logic [RAW-1:0] ra1;
  logic [RAW-1:0] ra2;
  logic           load_en;
  logic           wren_mem;
  logic           wren_reg;
  logic           cr_taken;
  logic           illegal;
  logic           halted;

  modport master (
    output ir_valid, ir, stall,
    input  ir_ready, phase, op, im, use_im, br, ra1, ra2,
           load_en, wren_mem, wren_reg, cr_taken, illegal, halted
  );

  modport slave (
    input  ir_valid, ir, stall,
    output ir_ready, phase, op, im, use_im, br, ra1, ra2,
           load_en, wren_mem, wren_reg, cr_taken, illegal, halted
  );
endinterface

// File: rtl/decoder_seq_comb.sv
// Pure combinational instruction decode: ir -> control fields, immediate, register
// addresses and an illegal flag. Illegal encodings collapse to a harmless ADD.
module decoder_seq_comb
  import ji3_pkg::*;
#(
  parameter int DW      = 32,
  parameter int RAW     = 3,
  parameter int SEXT_IM = 1,
  parameter int JMP_OFS = 3
) (
  input  logic [31:0]    ir,
  output ctl_t           ctl,
  output logic [DW-1:0]  im,
  output logic [RAW-1:0] ra1,
  output logic [RAW-1:0] ra2,
  output logic           illegal
);
  logic          bad;
  logic [DW-1:0] imm_ext;
  wire           unused_ir_lo = ^ir[7:0];

  assign ra1 = ir[19+RAW-1 -: RAW];
  assign ra2 = ir[16+RAW-1 -: RAW];

  always_comb begin
    if (SEXT_IM != 0) imm_ext = DW'($signed(ir[15:8]));
    else              imm_ext = DW'(ir[15:8]);
  end

  always_comb begin
    ctl = '0;
    ctl.op = OP_ADD;
    bad = 1'b0;
    im = '0;
    case (ir[31:24])
      OPC_LD:    begin ctl.op = OP_LD; ctl.load = 1'b1; ctl.wr_reg = 1'b1; end
      OPC_MOVST: begin
        if (ir[23:22] == 2'b11) begin ctl.op = OP_MOV; ctl.wr_reg = 1'b1; end
        else                    begin ctl.op = OP_ST;  ctl.st = 1'b1;     end
      end
      OPC_LIL:   begin ctl.op = OP_LIL; ctl.use_im = 1'b1; ctl.wr_reg = 1'b1; end
      OPC_ADD:   begin ctl.op = OP_ADD; ctl.wr_reg = 1'b1; end
      OPC_SUB:   begin ctl.op = OP_SUB; ctl.wr_reg = 1'b1; end
      OPC_CMP:   ctl.op = OP_CMP;
      OPC_AND:   begin ctl.op = OP_AND; ctl.wr_reg = 1'b1; end
      OPC_OR:    begin ctl.op = OP_OR;  ctl.wr_reg = 1'b1; end
      OPC_XOR:   begin ctl.op = OP_XOR; ctl.wr_reg = 1'b1; end
      OPC_ALUI: begin
        ctl.use_im = 1'b1;
        ctl.wr_reg = 1'b1;
        case (ir[23:19])
          5'b11000: ctl.op = OP_ADD;
          5'b11101: ctl.op = OP_SUB;
          5'b11111: begin ctl.op = OP_CMP; ctl.wr_reg = 1'b0; end
          5'b11100: ctl.op = OP_AND;
          5'b11001: ctl.op = OP_OR;
          5'b11110: ctl.op = OP_XOR;
          default:  bad = 1'b1;
        endcase
      end
      OPC_UNARY: begin
        ctl.wr_reg = 1'b1;
        case (ir[23:19])
          5'b11011: ctl.op = OP_NEG;
          5'b11010: ctl.op = OP_NOT;
          default:  bad = 1'b1;
        endcase
      end
      OPC_SHI: begin
        ctl.use_im = 1'b1;
        ctl.wr_reg = 1'b1;
        case (ir[23:19])
          5'b11100: ctl.op = OP_SLL;
          5'b11101: ctl.op = OP_SRL;
          5'b11111: ctl.op = OP_SRA;
          default:  bad = 1'b1;
        endcase
      end
      OPC_JMP: begin
        ctl.use_im = 1'b1;
        ctl.jmp = 1'b1;
        case (ir[23:20])
          4'b1110: ctl.br = BR_B;
          4'b0111: ctl.br = BR_BCC;
          default: bad = 1'b1;
        endcase
      end
      OPC_HLT:   begin ctl.op = OP_HLT; ctl.hlt = 1'b1; end
      default:   bad = 1'b1;
    endcase
    // Jump displacement is relative to the next instruction, hence the length offset.
    if (ctl.use_im) im = ctl.jmp ? imm_ext + DW'(JMP_OFS) : imm_ext;
    if (bad) begin
      ctl = '0;
      ctl.op = OP_ADD;
      im = '0;
    end
    illegal = bad;
  end
endmodule

// File: rtl/decoder_seq.sv
// ji3 decoder with its own F/R/X/M/W phase sequencer: accepts one instruction per
// handshake in F, holds decoded fields until the next accept, and times write strobes.
module decoder_seq
  import ji3_pkg::*;
#(
  parameter int DW      = 32,
  parameter int RAW     = 3,
  parameter int SEXT_IM = 1,
  parameter int JMP_OFS = 3
) (
  input logic          clk,
  input logic          rst,
  decoder_seq_if.slave bus
);
  state_t         state, state_n;
  ctl_t           ctl_d, ctl_q;
  logic [DW-1:0]  im_d, im_q;
  logic [RAW-1:0] ra1_d, ra2_d, ra1_q, ra2_q;
  logic           ill_d, ill_q;
  logic           halted_q, wren_mem_q, wren_reg_q, cr_taken_q;
  logic           ready, accept;
  logic [4:0]     phase;

  decoder_seq_comb #(.DW(DW), .RAW(RAW), .SEXT_IM(SEXT_IM), .JMP_OFS(JMP_OFS)) u_comb (
    .ir(bus.ir), .ctl(ctl_d), .im(im_d), .ra1(ra1_d), .ra2(ra2_d), .illegal(ill_d)
  );

  assign ready  = (state == S_F) & ~bus.stall & ~halted_q & ~rst;
  assign accept = bus.ir_valid & ready;

  always_comb begin
    state_n = state;
    if (!bus.stall) begin
      case (state)
        S_F:     if (accept) state_n = S_R;
        S_R:     state_n = S_X;
        S_X:     state_n = S_M;
        S_M:     state_n = S_W;
        S_W:     state_n = S_F;
        default: state_n = S_F;
      endcase
    end
  end

  always_comb begin
    phase = '0;
    case (state)
      S_F:     phase[PH_F] = 1'b1;
      S_R:     phase[PH_R] = 1'b1;
      S_X:     phase[PH_X] = 1'b1;
      S_M:     phase[PH_M] = 1'b1;
      S_W:     phase[PH_W] = 1'b1;
      default: phase[PH_F] = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_F;
      ctl_q      <= '0;
      im_q       <= '0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      ill_q      <= 1'b0;
      halted_q   <= 1'b0;
      wren_mem_q <= 1'b0;
      wren_reg_q <= 1'b0;
      cr_taken_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        ctl_q <= ctl_d;
        im_q  <= im_d;
        ra1_q <= ra1_d;
        ra2_q <= ra2_d;
        ill_q <= ill_d;
      end
      // Strobes are registered against the phase being entered; a stall freezes them.
      if (!bus.stall) begin
        wren_mem_q <= (state_n == S_X) & ctl_q.st;
        wren_reg_q <= (state_n == S_M) & ctl_q.wr_reg;
        cr_taken_q <= (state_n == S_M) & ctl_q.jmp;
        if (state == S_W && ctl_q.hlt) halted_q <= 1'b1;
      end
    end
  end

  assign bus.ir_ready = ready;
  assign bus.phase    = phase;
  assign bus.op       = ctl_q.op;
  assign bus.im       = im_q;
  assign bus.use_im   = ctl_q.use_im;
  assign bus.br       = ctl_q.br;
  assign bus.ra1      = ra1_q;
  assign bus.ra2      = ra2_q;
  assign bus.load_en  = ctl_q.load;
  assign bus.wren_mem = wren_mem_q;
  assign bus.wren_reg = wren_reg_q;
  assign bus.cr_taken = cr_taken_q;
  assign bus.illegal  = ill_q;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: a sign-extending and a zero-extending instance run
// the same instruction stream; each phase of every instruction is checked.
module tb_decoder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic [3:0] exp_q[$];

  decoder_seq_if #(.DW(32), .RAW(3)) bus ();
  decoder_seq_if #(.DW(32), .RAW(3)) bus_z ();

  decoder_seq #(.DW(32), .RAW(3), .SEXT_IM(1), .JMP_OFS(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  decoder_seq #(.DW(32), .RAW(3), .SEXT_IM(0), .JMP_OFS(3)) dut_z (
    .clk(clk), .rst(rst), .bus(bus_z)
  );

  assign bus_z.ir_valid = bus.ir_valid;
  assign bus_z.ir       = bus.ir;
  assign bus_z.stall    = bus.stall;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present instr and wait (bounded) for the handshake; returns in the R cycle.
  task automatic issue(input logic [31:0] instr, output bit ok);
    bus.ir = instr;
    bus.ir_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ir_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.ir_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic run(input string tag, input logic [31:0] instr, input logic [3:0] e_op,
                     input logic e_use, input logic [31:0] e_im, input logic [31:0] e_imz,
                     input logic [1:0] e_br, input logic e_ld, input logic e_mem,
                     input logic e_reg, input logic e_cr, input logic e_ill);
    bit ok;
    exp_q.push_back(e_op);
    issue(instr, ok);
    check({tag, "_r_phase"}, bus.phase, 5'b00010);
    check({tag, "_op"}, bus.op, exp_q.pop_front());
    check({tag, "_use_im"}, bus.use_im, e_use);
    check({tag, "_im"}, bus.im, e_im);
    check({tag, "_im_zext"}, bus_z.im, e_imz);
    check({tag, "_br"}, bus.br, e_br);
    check({tag, "_illegal"}, bus.illegal, e_ill);
    check({tag, "_r_load"}, bus.load_en, e_ld);
    check({tag, "_r_strobes"}, {bus.wren_mem, bus.wren_reg, bus.cr_taken}, 3'b000);
    step();
    check({tag, "_x_phase"}, bus.phase, 5'b00100);
    check({tag, "_x_strobes"}, {bus.wren_mem, bus.wren_reg, bus.cr_taken}, {e_mem, 2'b00});
    step();
    check({tag, "_m_phase"}, bus.phase, 5'b01000);
    check({tag, "_m_strobes"}, {bus.wren_mem, bus.wren_reg, bus.cr_taken}, {1'b0, e_reg, e_cr});
    check({tag, "_m_load"}, bus.load_en, e_ld);
    step();
    check({tag, "_w_phase"}, bus.phase, 5'b10000);
    check({tag, "_w_strobes"}, {bus.wren_mem, bus.wren_reg, bus.cr_taken}, 3'b000);
    check({tag, "_w_load"}, bus.load_en, e_ld);
    step();
    check({tag, "_f_phase"}, bus.phase, 5'b00001);
  endtask

  initial begin
    bit ok;
    int acc_st;
    bus.ir_valid = 1'b0;
    bus.ir = 32'h0;
    bus.stall = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    check("rst_phase", bus.phase, 5'b00001);
    check("rst_ready", bus.ir_ready, 1'b0);
    check("rst_outs", {bus.op, bus.im, bus.use_im, bus.br, bus.ra1, bus.ra2, bus.load_en,
                       bus.wren_mem, bus.wren_reg, bus.cr_taken, bus.illegal, bus.halted}, 0);
    rst = 1'b0;

    // register ALU op from reset
    run("add", 32'h01D0_0000, 4'd0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 1, 0, 0);
    check("add_ra1", bus.ra1, 3'd2);
    check("add_ra2", bus.ra2, 3'd0);

    // ST then LD back-to-back, 5-clock accept period
    run("st", 32'h8908_0000, 4'd12, 0, 32'h0, 32'h0, 2'b00, 0, 1, 0, 0, 0);
    acc_st = last_acc;
    run("ld", 32'h8B10_0000, 4'd11, 0, 32'h0, 32'h0, 2'b00, 1, 0, 1, 0, 0);
    check("st_ld_period", last_acc - acc_st, 5);

    // immediates, compare, jumps, illegal encodings
    run("addi", 32'h83C0_FF00, 4'd0, 1, 32'hFFFF_FFFF, 32'h0000_00FF, 2'b00, 0, 0, 1, 0, 0);
    run("subi", 32'h83E8_0400, 4'd1, 1, 32'h4, 32'h4, 2'b00, 0, 0, 1, 0, 0);
    run("cmp", 32'h3910_0000, 4'd2, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    run("sra", 32'hC1F8_8000, 4'd10, 1, 32'hFFFF_FF80, 32'h80, 2'b00, 0, 0, 1, 0, 0);
    run("jmp", 32'h90E0_FE00, 4'd0, 1, 32'h1, 32'h101, 2'b10, 0, 0, 0, 1, 0);
    run("jcc", 32'h9070_0500, 4'd0, 1, 32'h8, 32'h8, 2'b01, 0, 0, 0, 1, 0);
    run("jbad", 32'h9000_0500, 4'd0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 1);
    run("opc_bad", 32'h0000_0000, 4'd0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 1);

    // stall for 3 cycles in X of a store
    issue(32'h8908_0000, ok);
    step();
    check("stall_x_mem", bus.wren_mem, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_phase", bus.phase, 5'b00100);
      check("stall_hold_mem", bus.wren_mem, 1'b1);
    end
    bus.stall = 1'b0;
    step();
    check("stall_rel_phase", bus.phase, 5'b01000);
    check("stall_rel_mem", bus.wren_mem, 1'b0);
    repeat (2) step();

    // stall in F blocks acceptance
    bus.stall = 1'b1;
    bus.ir = 32'h01D0_0000;
    bus.ir_valid = 1'b1;
    repeat (2) step();
    check("stall_f_phase", bus.phase, 5'b00001);
    check("stall_f_ready", bus.ir_ready, 1'b0);
    bus.ir_valid = 1'b0;
    bus.stall = 1'b0;

    // halt is sticky until reset
    run("hlt", 32'hF400_0000, 4'd15, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    check("hlt_halted", bus.halted, 1'b1);
    bus.ir = 32'h01D0_0000;
    bus.ir_valid = 1'b1;
    repeat (3) step();
    check("hlt_phase_f", bus.phase, 5'b00001);
    check("hlt_ready", bus.ir_ready, 1'b0);
    bus.ir_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hlt_rst_phase", bus.phase, 5'b00001);
    check("hlt_rst_halted", bus.halted, 1'b0);
    check("hlt_rst_op", bus.op, 4'd0);

    // reset in M drops the register write strobe
    issue(32'h01D0_0000, ok);
    repeat (2) step();
    check("mid_m_reg", bus.wren_reg, 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_reg", bus.wren_reg, 1'b0);
    check("mid_rst_phase", bus.phase, 5'b00001);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
